poly_addsub_ctrl: RTL and testbench

- Sequencer that runs the shared 12-bit modular add/sub unit (q = 3329) across a full Kyber polynomial.
- Streams coefficient pairs from two coefficient RAMs through the adder and writes results to a destination RAM, one coefficient per cycle.
- Sits between the polynomial-arithmetic top-level FSM (start/done handshake) and the add unit plus coefficient memories.

---
 rtl/poly_addsub_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_poly_addsub_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// poly_addsub_ctrl
// Sequencer that streams one full polynomial (N coefficients) from source RAMs
// A and B through the shared modular add/sub unit (q = 3329) and writes each
// result to a destination RAM, one coefficient per cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, mode           one-cycle request with operation (1 add, 0 sub,
//                         2/3 illegal); accepted only while idle
//   busy, done, err       status: busy through the done cycle, one-cycle done,
//                         err pulses with done on illegal mode / range fault
//   rd_en, rd_addr        shared read strobe/address for source RAMs A and B
//   a_rdata, b_rdata      source data, valid one cycle after rd_en
//   add_in1/2, add_mode   operands and latched mode towards the adder
//   add_out               combinational adder result
//   wr_en, wr_addr,       destination RAM write port (wr_data = add_out)
//   wr_data
//
// Optional feature: define POLY_ADDSUB_RANGE_CHK_EN to flag any source
// coefficient >= Q seen during a write cycle; the sticky flag raises err
// together with done.
// -----------------------------------------------------------------------------
module poly_addsub_ctrl #(
  parameter int N  = 256,
  parameter int W  = 12,
  parameter int Q  = 3329,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  a_rdata,
  input  logic [W-1:0]  b_rdata,
  output logic [W-1:0]  add_in1,
  output logic [W-1:0]  add_in2,
  output logic [1:0]    add_mode,
  input  logic [W-1:0]  add_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data
);

  localparam logic [AW-1:0] last_addr = AW'(N - 1);
  localparam logic [W-1:0]  q_lim     = W'(Q);

`ifdef POLY_ADDSUB_RANGE_CHK_EN
  localparam logic range_chk_en = 1'b1;
`else
  localparam logic range_chk_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_run   = 2'd1,
    st_drain = 2'd2,
    st_done  = 2'd3
  } state_t;

  // True when either operand lies outside the canonical range [0, Q).
  function automatic logic coef_out_of_range(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    return (a >= q_lim) || (b >= q_lim);
  endfunction

  state_t          state_r, state_s;
  logic            rd_en_r, rd_en_s;
  logic [AW-1:0]   rd_addr_r, rd_addr_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            err_r, err_s;
  logic [1:0]      mode_r, mode_s;
  logic            fault_r, fault_s;
  logic            fault_hit_s;
  logic            wr_en_r;
  logic [AW-1:0]   wr_addr_r;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_s   = state_r;
    rd_en_s   = 1'b0;
    rd_addr_s = rd_addr_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    mode_s    = mode_r;
    // Source data on a write cycle is exactly the data feeding the adder.
    fault_hit_s = range_chk_en & wr_en_r & coef_out_of_range(a_rdata, b_rdata);
    fault_s     = fault_r | fault_hit_s;
    case (state_r)
      st_idle: begin
        busy_s = 1'b0;
        if (start) begin
          fault_s = 1'b0;
          busy_s  = 1'b1;
          if (mode[1]) begin
            // Illegal operation: report immediately, touch no memory.
            state_s = st_done;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s   = st_run;
            mode_s    = mode;
            rd_en_s   = 1'b1;
            rd_addr_s = {AW{1'b0}};
          end
        end else begin
          state_s = st_idle;
        end
      end
      st_run: begin
        busy_s = 1'b1;
        if (rd_addr_r == last_addr) begin
          // Last address already issued; counter holds instead of wrapping.
          state_s = st_drain;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = rd_addr_r + AW'(1);
        end
      end
      st_drain: begin
        // The final write happens in this cycle, so its fault check is folded in.
        state_s = st_done;
        busy_s  = 1'b1;
        done_s  = 1'b1;
        err_s   = fault_s;
      end
      st_done: begin
        state_s = st_idle;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = st_idle;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= st_idle;
      rd_en_r   <= 1'b0;
      rd_addr_r <= {AW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      mode_r    <= 2'd0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_en_r   <= rd_en_s;
      rd_addr_r <= rd_addr_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      mode_r    <= mode_s;
      fault_r   <= fault_s;
    end
  end

  // Write pipeline: one cycle behind the read, matching the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
    end else begin
      wr_en_r   <= rd_en_r;
      wr_addr_r <= rd_addr_r;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign rd_en    = rd_en_r;
  assign rd_addr  = rd_addr_r;
  assign add_in1  = a_rdata;
  assign add_in2  = b_rdata;
  assign add_mode = mode_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = add_out;

endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_poly_addsub_ctrl
// Self-checking bench: emulates the source RAMs and the modular adder, keeps a
// cycle-offset model of every operation (accept edge, latched mode, fault) and
// compares all DUT outputs against it on every falling edge. Directed scenarios
// add literal expectations; a randomized phase adds start chatter and modes.
// -----------------------------------------------------------------------------
module tb_poly_addsub_ctrl;

  localparam int N = 256;
  localparam int Q = 3329;
`ifdef POLY_ADDSUB_RANGE_CHK_EN
  localparam bit range_en = 1'b1;
`else
  localparam bit range_en = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        busy, done, err, rd_en, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [11:0] a_rdata = 12'd0;
  logic [11:0] b_rdata = 12'd0;
  logic [11:0] add_in1, add_in2, add_out, wr_data;
  logic [1:0]  add_mode;

  logic [11:0] ram_a [0:N-1];
  logic [11:0] ram_b [0:N-1];

  int total = 0;
  int bad   = 0;

  // model state
  int e = 0;
  int e0 = 0;
  int next_ok = 0;
  bit active = 1'b0;
  bit legal_m = 1'b0;
  bit fault_m = 1'b0;
  logic [1:0] mode_m = 2'd0;

  // captures for literal checks
  int busy_cnt, wr_cnt, last_wd, last_err;
  int acc_e, done_e;
  bit got;

  poly_addsub_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .add_in1(add_in1), .add_in2(add_in2), .add_mode(add_mode),
    .add_out(add_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_op(input int a, input int b, input int m);
    if (m == 1) return (a + b) % Q;
    else if (m == 0) return ((a - b) % Q + Q) % Q;
    else return 0;
  endfunction

  function automatic bit any_fault();
    for (int i = 0; i < N; i++)
      if (int'(ram_a[i]) >= Q || int'(ram_b[i]) >= Q) return 1'b1;
    return 1'b0;
  endfunction

  // source RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= ram_a[rd_addr];
      b_rdata <= ram_b[rd_addr];
    end
  end

  // adder environment
  always_comb add_out = 12'(ref_op(int'(add_in1), int'(add_in2), int'(add_mode)));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // operation model: decides on each edge whether a start is accepted
  initial forever begin
    @(posedge clk);
    e = e + 1;
    if (!rst_n) begin
      active = 1'b0; mode_m = 2'd0; next_ok = 0;
    end else if (start && e >= next_ok) begin
      active = 1'b1;
      e0 = e;
      if (mode[1]) begin
        legal_m = 1'b0;
        next_ok = e + 2;
      end else begin
        legal_m = 1'b1;
        mode_m  = mode;
        next_ok = e + N + 3;
        fault_m = range_en && any_fault();
      end
    end
  end

  // per-cycle comparison against the model
  initial begin : compare
    int d;
    bit xb, xd, xe, xr, xw;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        chk("rst rd_en", int'(rd_en), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst rd_addr", int'(rd_addr), 0);
        chk("rst wr_addr", int'(wr_addr), 0);
        chk("rst add_mode", int'(add_mode), 0);
      end else begin
        xb = 0; xd = 0; xe = 0; xr = 0; xw = 0; d = e - e0;
        if (active) begin
          if (legal_m) begin
            xb = (d >= 0 && d <= N + 1);
            xr = (d >= 0 && d <= N - 1);
            xw = (d >= 1 && d <= N);
            xd = (d == N + 1);
            xe = xd && fault_m;
          end else begin
            xb = (d == 0); xd = xb; xe = xb;
          end
        end
        chk("busy", int'(busy), int'(xb));
        chk("done", int'(done), int'(xd));
        chk("err", int'(err), int'(xe));
        chk("rd_en", int'(rd_en), int'(xr));
        chk("wr_en", int'(wr_en), int'(xw));
        chk("add_mode", int'(add_mode), int'(mode_m));
        if (xr) chk("rd_addr", int'(rd_addr), d);
        if (xw) begin
          chk("wr_addr", int'(wr_addr), d - 1);
          chk("wr_data", int'(wr_data),
              ref_op(int'(ram_a[d-1]), int'(ram_b[d-1]), int'(mode_m)));
        end
        if (busy) busy_cnt++;
        if (wr_en) begin wr_cnt++; last_wd = int'(wr_data); end
        if (done) last_err = int'(err);
      end
    end
  end

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < N; i++) begin
      ram_a[i] = 12'(av); ram_b[i] = 12'(bv);
    end
  endtask

  task automatic fill_rand(input bit wide);
    for (int i = 0; i < N; i++) begin
      ram_a[i] = 12'($urandom_range(0, wide ? 4095 : Q - 1));
      ram_b[i] = 12'($urandom_range(0, wide ? 4095 : Q - 1));
    end
  endtask

  // issue one start and wait (bounded) for done
  task automatic run_op(input logic [1:0] m, input bit chatter, input bit hold);
    @(posedge clk); #1;
    start = 1'b1; mode = m; acc_e = e + 1;
    busy_cnt = 0; wr_cnt = 0; last_wd = -1; last_err = -1; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (hold) begin
        start = 1'b1; mode = mode ^ 2'd1;
      end else if (chatter) begin
        start = ($urandom_range(0, 3) == 0);
        mode  = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin got = 1'b1; done_e = e; break; end
    end
    chk("op timeout", int'(got), 1);
    if (!hold) begin
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("wait timeout", int'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0;
    fill(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset rd_en", int'(rd_en), 0);
    chk("reset done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic add: 10 + 301
    fill(10, 301);
    run_op(2'd1, 1'b0, 1'b0);
    chk("add latency", done_e + 1 - acc_e, 258);
    chk("add busy cycles", busy_cnt, 258);
    chk("add writes", wr_cnt, 256);
    chk("add data", last_wd, 311);
    chk("add err", last_err, 0);

    // wrap and subtract borrow
    fill(3300, 29);
    run_op(2'd1, 1'b0, 1'b0);
    chk("wrap data", last_wd, 0);
    chk("wrap writes", wr_cnt, 256);
    fill(0, 50);
    run_op(2'd0, 1'b0, 1'b0);
    chk("sub data", last_wd, 3279);

    // illegal mode
    run_op(2'd2, 1'b0, 1'b0);
    chk("illegal latency", done_e + 1 - acc_e, 1);
    chk("illegal writes", wr_cnt, 0);
    chk("illegal err", last_err, 1);
    chk("illegal busy", busy_cnt, 1);

    // start held with mode toggling: one op, then re-accept after done
    fill_rand(1'b0);
    run_op(2'd1, 1'b0, 1'b1);
    chk("hold add_mode", int'(add_mode), 1);
    chk("hold busy cycles", busy_cnt, 258);
    @(negedge clk);
    chk("hold gap busy", int'(busy), 0);
    @(negedge clk);
    chk("hold reaccept busy", int'(busy), 1);
    chk("hold reaccept rd_addr", int'(rd_addr), 0);
    @(posedge clk); #1; start = 1'b0; mode = 2'd0;
    wait_done();

    // range fault at coefficient 17, then a clean run
    fill(100, 200);
    ram_a[17] = 12'd3329;
    run_op(2'd1, 1'b0, 1'b0);
    chk("range writes", wr_cnt, 256);
    chk("range err", last_err, int'(range_en));
    fill(100, 200);
    run_op(2'd1, 1'b0, 1'b0);
    chk("clean err", last_err, 0);

    // reset in the middle of RUN
    fill_rand(1'b0);
    @(posedge clk); #1; start = 1'b1; mode = 2'd1;
    @(posedge clk); #1; start = 1'b0;
    repeat (99) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst rd_en", int'(rd_en), 0);
    chk("midrst wr_en", int'(wr_en), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    run_op(2'd0, 1'b0, 1'b0);
    chk("postrst latency", done_e + 1 - acc_e, 258);
    chk("postrst writes", wr_cnt, 256);

    // randomized operations with start chatter while busy
    for (int k = 0; k < 20; k++) begin
      int r;
      logic [1:0] m;
      fill_rand($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 7);
      m = (r < 6) ? 2'(r % 2) : 2'(2 + r % 2);
      run_op(m, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
